// File: rtl/branch_stall_sequencer.sv
// Stall/flush sequencer for branches resolved in ID of the 5-stage MIPS core.
// Optional stall statistics counter is built only when STALL_STATS_EN is defined.
module branch_stall_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  rs_ID,
  input  logic [2:0]  rt_ID,
  input  logic        branch_ID,
  input  logic        branchTaken_ID,
  input  logic [2:0]  rd_EX,
  input  logic        writeEnableRF_EX,
  input  logic        loadEx,
  input  logic [2:0]  rd_MEM,
  input  logic        loadMem,
  input  logic        extStall,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        idexBubble,
  output logic        ifidFlush,
  output logic [1:0]  stallCode,
  output logic [15:0] stallCycles,
  output logic        fsm_state
);

  typedef enum logic {
    RUN      = 1'b0,
    LOADWAIT = 1'b1
  } state_t;

  state_t state, state_next;

  logic hit_ex;
  logic hit_mem;
  logic h_lex;
  logic h_alu;
  logic h_lmem;

  // Register 0 is hardwired, so it never creates a dependency.
  assign hit_ex  = (rd_EX  != 3'd0) && ((rd_EX  == rs_ID) || (rd_EX  == rt_ID));
  assign hit_mem = (rd_MEM != 3'd0) && ((rd_MEM == rs_ID) || (rd_MEM == rt_ID));

  assign h_lex  = branch_ID && loadEx && hit_ex;
  assign h_alu  = branch_ID && writeEnableRF_EX && !loadEx && hit_ex;
  assign h_lmem = branch_ID && loadMem && hit_mem;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    idexBubble = 1'b0;
    ifidFlush  = 1'b0;
    stallCode  = 2'b00;

    if (rst) begin
      state_next = RUN;
    end else if (extStall) begin
      // Whole pipeline frozen: no bubble, state and counter hold.
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
    end else if (state == LOADWAIT) begin
      // Second load-use stall; hazard inputs are deliberately ignored here.
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
      stallCode  = 2'b10;
      state_next = RUN;
    end else if (h_lex) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
      stallCode  = 2'b10;
      state_next = LOADWAIT;
    end else if (h_alu || h_lmem) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
      stallCode  = h_alu ? 2'b01 : 2'b10;
    end else if (branch_ID && branchTaken_ID) begin
      ifidFlush = 1'b1;
    end
  end

`ifdef STALL_STATS_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (idexBubble && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stallCycles = stall_cnt;
`else
  assign stallCycles = 16'd0;
`endif

endmodule

// File: tb/tb_branch_stall_sequencer.sv
// Self-checking bench for branch_stall_sequencer: directed scenarios plus
// randomized cycles, all scored against a stall-budget reference model.
module tb_branch_stall_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rs_ID, rt_ID, rd_EX, rd_MEM;
  logic        branch_ID, branchTaken_ID, writeEnableRF_EX, loadEx, loadMem, extStall;
  logic        pcWrite, ifidWrite, idexBubble, ifidFlush, fsm_state;
  logic [1:0]  stallCode;
  logic [15:0] stallCycles;

  int checks = 0;
  int failures = 0;

  // Reference model: outstanding forced stall cycles and stall count.
  int m_wait = 0;
  int m_cnt  = 0;
  int m_need = 0;
  logic [6:0]  exp_q[$];
  logic [15:0] cnt_q[$];
  logic [6:0]  obs_v;
  logic [15:0] obs_c;
  logic [6:0]  ev;
  logic [15:0] ec;

  branch_stall_sequencer dut (
    .clk(clk), .rst(rst), .rs_ID(rs_ID), .rt_ID(rt_ID), .branch_ID(branch_ID),
    .branchTaken_ID(branchTaken_ID), .rd_EX(rd_EX), .writeEnableRF_EX(writeEnableRF_EX),
    .loadEx(loadEx), .rd_MEM(rd_MEM), .loadMem(loadMem), .extStall(extStall),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexBubble(idexBubble),
    .ifidFlush(ifidFlush), .stallCode(stallCode), .stallCycles(stallCycles),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic ext, input logic br, input logic tk,
                       input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rde,
                       input logic we, input logic ld, input logic [2:0] rdm, input logic lm);
    rst = r; extStall = ext; branch_ID = br; branchTaken_ID = tk;
    rs_ID = rs; rt_ID = rt; rd_EX = rde; writeEnableRF_EX = we; loadEx = ld;
    rd_MEM = rdm; loadMem = lm;
  endtask

  // ---------------- model ----------------
  // Expected vector layout: {pcWrite, ifidWrite, idexBubble, ifidFlush, stallCode, in_loadwait}
  task automatic model_predict();
    logic dep_ex, dep_mem, lex, alu, lmem;
    logic [1:0] code;
    logic stall, flush;
    dep_ex  = (rd_EX != 0) && (rd_EX == rs_ID || rd_EX == rt_ID);
    dep_mem = (rd_MEM != 0) && (rd_MEM == rs_ID || rd_MEM == rt_ID);
    lex  = branch_ID && loadEx && dep_ex;
    alu  = branch_ID && writeEnableRF_EX && !loadEx && dep_ex;
    lmem = branch_ID && loadMem && dep_mem;
    m_need = 0; code = 2'b00; stall = 1'b0; flush = 1'b0;
    if (rst) begin
      exp_q.push_back({4'b1100, 2'b00, (m_wait > 0)});
    end else if (extStall) begin
      exp_q.push_back({4'b0000, 2'b00, (m_wait > 0)});
    end else begin
      if (m_wait > 0) begin
        stall = 1'b1; code = 2'b10;
      end else if (branch_ID) begin
        if (lex)       begin m_need = 2; code = 2'b10; end
        else if (alu)  begin m_need = 1; code = 2'b01; end
        else if (lmem) begin m_need = 1; code = 2'b10; end
        stall = (m_need > 0);
        flush = !stall && branchTaken_ID;
      end
      exp_q.push_back({!stall, !stall, stall, flush, code, (m_wait > 0)});
    end
`ifdef STALL_STATS_EN
    cnt_q.push_back(m_cnt[15:0]);
`else
    cnt_q.push_back(16'd0);
`endif
  endtask

  task automatic model_advance(input logic bubbled);
    if (rst) begin
      m_wait = 0; m_cnt = 0;
    end else if (!extStall) begin
      if (bubbled && m_cnt < 65535) m_cnt++;
      if (m_wait > 0) m_wait--;
      else if (m_need == 2) m_wait = 1;
    end
  endtask

  // One clock: predict and sample mid-cycle, then advance the model on the edge.
  task automatic run_cycle();
    logic bub;
    @(negedge clk);
    model_predict();
    bub   = exp_q[$][4];
    obs_v = {pcWrite, ifidWrite, idexBubble, ifidFlush, stallCode, fsm_state};
    obs_c = stallCycles;
    @(posedge clk);
    model_advance(bub);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1, c[0], 1, 1, 3, 5, 3, 0, 1, 5, 1);
      run_cycle();
      ev = exp_q.pop_front(); ec = cnt_q.pop_front();
      checks++;
      if (obs_v !== ev) begin failures++; $display("FAIL reset c%0d outs got=%b exp=%b", c, obs_v, ev); end
      checks++;
      if (obs_c !== ec) begin failures++; $display("FAIL reset c%0d cnt got=%0d exp=%0d", c, obs_c, ec); end
    end
  endtask

  task automatic test_alu_stall();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: drive(0, 0, 1, 0, 3, 1, 3, 1, 0, 0, 0);
        1: drive(0, 0, 1, 0, 3, 1, 3, 0, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      run_cycle();
      ev = exp_q.pop_front(); ec = cnt_q.pop_front();
      checks++;
      if (obs_v !== ev) begin failures++; $display("FAIL alu_stall c%0d outs got=%b exp=%b", c, obs_v, ev); end
      checks++;
      if (obs_c !== ec) begin failures++; $display("FAIL alu_stall c%0d cnt got=%0d exp=%0d", c, obs_c, ec); end
    end
  endtask

  task automatic test_load_stall();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: drive(0, 0, 1, 0, 2, 5, 5, 1, 1, 0, 0);
        1: drive(0, 0, 1, 0, 2, 5, 0, 0, 0, 5, 1);
        2: drive(0, 0, 1, 1, 2, 5, 0, 0, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      run_cycle();
      ev = exp_q.pop_front(); ec = cnt_q.pop_front();
      checks++;
      if (obs_v !== ev) begin failures++; $display("FAIL load_stall c%0d outs got=%b exp=%b", c, obs_v, ev); end
      checks++;
      if (obs_c !== ec) begin failures++; $display("FAIL load_stall c%0d cnt got=%0d exp=%0d", c, obs_c, ec); end
    end
  endtask

  task automatic test_zero_reg();
    drive(0, 0, 1, 1, 0, 4, 0, 1, 1, 0, 1);
    run_cycle();
    ev = exp_q.pop_front(); ec = cnt_q.pop_front();
    checks++;
    if (obs_v !== ev) begin failures++; $display("FAIL zero_reg outs got=%b exp=%b", obs_v, ev); end
    checks++;
    if (obs_c !== ec) begin failures++; $display("FAIL zero_reg cnt got=%0d exp=%0d", obs_c, ec); end
  endtask

  task automatic test_ext_stall();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0:       drive(0, 0, 1, 0, 6, 1, 6, 1, 1, 0, 0);
        1, 2, 3: drive(0, 1, 1, 0, 6, 1, 0, 0, 0, 6, 1);
        4:       drive(0, 0, 1, 0, 6, 1, 0, 0, 0, 6, 1);
        default: drive(0, 0, 1, 1, 6, 1, 0, 0, 0, 0, 0);
      endcase
      run_cycle();
      ev = exp_q.pop_front(); ec = cnt_q.pop_front();
      checks++;
      if (obs_v !== ev) begin failures++; $display("FAIL ext_stall c%0d outs got=%b exp=%b", c, obs_v, ev); end
      checks++;
      if (obs_c !== ec) begin failures++; $display("FAIL ext_stall c%0d cnt got=%0d exp=%0d", c, obs_c, ec); end
    end
  endtask

  task automatic test_reset_in_loadwait();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: drive(0, 0, 1, 0, 7, 2, 7, 1, 1, 0, 0);
        1: drive(1, 0, 1, 0, 7, 2, 0, 0, 0, 7, 1);
        default: drive(0, 0, 0, 0, 7, 2, 0, 0, 0, 0, 0);
      endcase
      run_cycle();
      ev = exp_q.pop_front(); ec = cnt_q.pop_front();
      checks++;
      if (obs_v !== ev) begin failures++; $display("FAIL rst_loadwait c%0d outs got=%b exp=%b", c, obs_v, ev); end
      checks++;
      if (obs_c !== ec) begin failures++; $display("FAIL rst_loadwait c%0d cnt got=%0d exp=%0d", c, obs_c, ec); end
    end
  endtask

  task automatic test_non_branch();
    drive(0, 0, 0, 1, 4, 1, 4, 1, 1, 4, 1);
    run_cycle();
    ev = exp_q.pop_front(); ec = cnt_q.pop_front();
    checks++;
    if (obs_v !== ev) begin failures++; $display("FAIL non_branch outs got=%b exp=%b", obs_v, ev); end
    checks++;
    if (obs_c !== ec) begin failures++; $display("FAIL non_branch cnt got=%0d exp=%0d", obs_c, ec); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: drive(0, 0, 1, 1, 1, 2, 2, 1, 0, 0, 0);
        1: drive(0, 0, 1, 1, 1, 2, 0, 0, 0, 0, 0);
        2: drive(0, 0, 1, 0, 3, 4, 0, 0, 0, 4, 1);
        default: drive(0, 0, 1, 0, 3, 4, 0, 0, 0, 0, 0);
      endcase
      run_cycle();
      ev = exp_q.pop_front(); ec = cnt_q.pop_front();
      checks++;
      if (obs_v !== ev) begin failures++; $display("FAIL back_to_back c%0d outs got=%b exp=%b", c, obs_v, ev); end
      checks++;
      if (obs_c !== ec) begin failures++; $display("FAIL back_to_back c%0d cnt got=%0d exp=%0d", c, obs_c, ec); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      run_cycle();
      ev = exp_q.pop_front(); ec = cnt_q.pop_front();
      checks++;
      if (obs_v !== ev) begin failures++; $display("FAIL random c%0d outs got=%b exp=%b", c, obs_v, ev); end
      checks++;
      if (obs_c !== ec) begin failures++; $display("FAIL random c%0d cnt got=%0d exp=%0d", c, obs_c, ec); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_stall();
    test_load_stall();
    test_zero_reg();
    test_ext_stall();
    test_reset_in_loadwait();
    test_non_branch();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
